// File: rtl/usb_txn_engine.sv
// rtl/usb_txn_engine.sv - host-side USB transaction engine with per-endpoint DATA0/DATA1 toggles
module usb_txn_engine #(
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 20,
  parameter int MAX_RETRY   = 8,
  parameter int NAK_LIMIT   = 15
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_dir,
  input  logic [6:0]        req_addr,
  input  logic [3:0]        req_endp,
  input  logic [DATA_W-1:0] req_data,
  input  logic              tog_clr,
  output logic              done,
  output logic [1:0]        done_code,
  output logic [DATA_W-1:0] rx_payload,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [3:0]        tx_pid,
  output logic [6:0]        tx_addr,
  output logic [3:0]        tx_endp,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_has_data,
  input  logic              rx_valid,
  input  logic [3:0]        rx_pid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_crc_err
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [1:0] CODE_OK    = 2'b00;
  localparam logic [1:0] CODE_RETRY = 2'b01;
  localparam logic [1:0] CODE_NAK   = 2'b10;
  localparam logic [1:0] CODE_STALL = 2'b11;

  localparam int TMO_W   = $clog2(TIMEOUT_CYC) + 1;
  localparam int RETRY_W = $clog2(MAX_RETRY) + 1;
  localparam int NAK_W   = $clog2(NAK_LIMIT) + 1;

  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0]   TMO_ONE    = TMO_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
  localparam logic [RETRY_W-1:0] RETRY_ONE  = RETRY_W'(1);
  localparam logic [NAK_W-1:0]   NAK_LAST   = NAK_W'(NAK_LIMIT - 1);
  localparam logic [NAK_W-1:0]   NAK_ONE    = NAK_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_TOKEN, S_DATA_TX, S_WAIT_HS, S_WAIT_DATA, S_SEND_ACK, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE, EV_ACK, EV_NAK, EV_STALL, EV_RETRY, EV_DATA, EV_DUP
  } event_t;

  state_t               state;
  event_t               ev;
  logic                 dir_r;
  logic [3:0]           endp_r;
  logic [DATA_W-1:0]    data_r;
  logic [15:0]          toggle;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [RETRY_W-1:0]   retry_cnt;
  logic [NAK_W-1:0]     nak_cnt;
  logic                 ack_final;
  logic                 waiting;
  logic                 rx_is_data;

  assign req_ready  = (state == S_IDLE);
  assign waiting    = (state == S_WAIT_HS) || (state == S_WAIT_DATA);
  assign rx_is_data = (rx_pid == PID_DATA0) || (rx_pid == PID_DATA1);

  // Classify what happened in a wait state this cycle; a response in the expiry cycle wins.
  always_comb begin
    ev = EV_NONE;
    if (waiting) begin
      if (rx_valid) begin
        if (rx_crc_err)
          ev = EV_RETRY;
        else if (rx_pid == PID_NAK)
          ev = EV_NAK;
        else if (rx_pid == PID_STALL)
          ev = EV_STALL;
        else if ((state == S_WAIT_HS) && (rx_pid == PID_ACK))
          ev = EV_ACK;
        else if ((state == S_WAIT_DATA) && rx_is_data)
          ev = ((rx_pid == PID_DATA1) == toggle[endp_r]) ? EV_DATA : EV_DUP;
        else
          ev = EV_RETRY;
      end else if (tmo_cnt == TMO_LAST) begin
        ev = EV_RETRY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state       <= S_IDLE;
      dir_r       <= 1'b0;
      endp_r      <= 4'd0;
      data_r      <= '0;
      toggle      <= '0;
      tmo_cnt     <= '0;
      retry_cnt   <= '0;
      nak_cnt     <= '0;
      ack_final   <= 1'b0;
      done        <= 1'b0;
      done_code   <= CODE_OK;
      rx_payload  <= '0;
      tx_valid    <= 1'b0;
      tx_pid      <= 4'd0;
      tx_addr     <= 7'd0;
      tx_endp     <= 4'd0;
      tx_data     <= '0;
      tx_has_data <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tog_clr)
            toggle <= '0;
          if (req_valid) begin
            dir_r       <= req_dir;
            endp_r      <= req_endp;
            data_r      <= req_data;
            tmo_cnt     <= '0;
            retry_cnt   <= '0;
            nak_cnt     <= '0;
            tx_addr     <= req_addr;
            tx_endp     <= req_endp;
            tx_valid    <= 1'b1;
            tx_pid      <= req_dir ? PID_IN : PID_OUT;
            tx_data     <= '0;
            tx_has_data <= 1'b0;
            state       <= S_TOKEN;
          end
        end
        S_TOKEN: begin
          if (tx_ready) begin
            tmo_cnt <= '0;
            if (dir_r) begin
              tx_valid <= 1'b0;
              state    <= S_WAIT_DATA;
            end else begin
              tx_pid      <= toggle[endp_r] ? PID_DATA1 : PID_DATA0;
              tx_data     <= data_r;
              tx_has_data <= 1'b1;
              state       <= S_DATA_TX;
            end
          end
        end
        S_DATA_TX: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            tmo_cnt  <= '0;
            state    <= S_WAIT_HS;
          end
        end
        S_WAIT_HS, S_WAIT_DATA: begin
          case (ev)
            EV_NONE: tmo_cnt <= tmo_cnt + TMO_ONE;
            EV_ACK: begin
              toggle[endp_r] <= ~toggle[endp_r];
              done           <= 1'b1;
              done_code      <= CODE_OK;
              state          <= S_DONE;
            end
            EV_STALL: begin
              done      <= 1'b1;
              done_code <= CODE_STALL;
              state     <= S_DONE;
            end
            EV_NAK: begin
              nak_cnt <= nak_cnt + NAK_ONE;
              if (nak_cnt == NAK_LAST) begin
                done      <= 1'b1;
                done_code <= CODE_NAK;
                state     <= S_DONE;
              end else begin
                tx_valid    <= 1'b1;
                tx_pid      <= dir_r ? PID_IN : PID_OUT;
                tx_data     <= '0;
                tx_has_data <= 1'b0;
                state       <= S_TOKEN;
              end
            end
            EV_RETRY: begin
              retry_cnt <= retry_cnt + RETRY_ONE;
              if (retry_cnt == RETRY_LAST) begin
                done      <= 1'b1;
                done_code <= CODE_RETRY;
                state     <= S_DONE;
              end else begin
                tx_valid    <= 1'b1;
                tx_pid      <= dir_r ? PID_IN : PID_OUT;
                tx_data     <= '0;
                tx_has_data <= 1'b0;
                state       <= S_TOKEN;
              end
            end
            EV_DATA, EV_DUP: begin
              if (ev == EV_DATA) begin
                rx_payload     <= rx_data;
                toggle[endp_r] <= ~toggle[endp_r];
              end
              // A duplicate is still ACKed so the device advances its own toggle.
              ack_final   <= (ev == EV_DATA);
              tx_valid    <= 1'b1;
              tx_pid      <= PID_ACK;
              tx_data     <= '0;
              tx_has_data <= 1'b0;
              state       <= S_SEND_ACK;
            end
            default: state <= S_IDLE;
          endcase
        end
        S_SEND_ACK: begin
          if (tx_ready) begin
            if (ack_final) begin
              tx_valid  <= 1'b0;
              done      <= 1'b1;
              done_code <= CODE_OK;
              state     <= S_DONE;
            end else begin
              tx_pid <= PID_IN;
              state  <= S_TOKEN;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_txn_engine.sv
// tb/tb_usb_txn_engine.sv - self-checking bench for usb_txn_engine with a protocol-level device model
module tb_usb_txn_engine;

  localparam int DATA_W      = 64;
  localparam int TIMEOUT_CYC = 20;
  localparam int MAX_RETRY   = 8;
  localparam int NAK_LIMIT   = 15;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  logic              clk;
  logic              rst_L;
  logic              req_valid, req_ready, req_dir, tog_clr;
  logic [6:0]        req_addr;
  logic [3:0]        req_endp;
  logic [DATA_W-1:0] req_data;
  logic              done;
  logic [1:0]        done_code;
  logic [DATA_W-1:0] rx_payload;
  logic              tx_valid, tx_ready, tx_has_data;
  logic [3:0]        tx_pid, tx_endp;
  logic [6:0]        tx_addr;
  logic [DATA_W-1:0] tx_data;
  logic              rx_valid, rx_crc_err;
  logic [3:0]        rx_pid;
  logic [DATA_W-1:0] rx_data;

  int total = 0;
  int bad   = 0;

  // Device-side view of the per-endpoint toggle the host should be using.
  logic [15:0] m_tog;

  bit                p_ok;
  int                p_wait;
  logic [3:0]        p_pid, p_endp;
  logic [6:0]        p_addr;
  logic [DATA_W-1:0] p_data;
  logic              p_hd;

  bit                w_ok;
  int                w_wait;
  logic [1:0]        w_code;
  logic [DATA_W-1:0] w_pay;
  logic              w_after, w_rr;

  usb_txn_engine #(
    .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY), .NAK_LIMIT(NAK_LIMIT)
  ) dut (
    .clk(clk), .rst_L(rst_L),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .req_addr(req_addr), .req_endp(req_endp), .req_data(req_data), .tog_clr(tog_clr),
    .done(done), .done_code(done_code), .rx_payload(rx_payload),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_pid(tx_pid), .tx_addr(tx_addr),
    .tx_endp(tx_endp), .tx_data(tx_data), .tx_has_data(tx_has_data),
    .rx_valid(rx_valid), .rx_pid(rx_pid), .rx_data(rx_data), .rx_crc_err(rx_crc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] data_pid(input logic t);
    return t ? PID_DATA1 : PID_DATA0;
  endfunction

  task automatic do_request(input logic dir, input logic [6:0] a, input logic [3:0] e,
                            input logic [DATA_W-1:0] d, input logic clr);
    req_valid = 1'b1; req_dir = dir; req_addr = a; req_endp = e; req_data = d; tog_clr = clr;
    @(negedge clk);
    req_valid = 1'b0; tog_clr = 1'b0;
  endtask

  // Captures the next offered packet, lets it be accepted and returns on the following negedge.
  task automatic get_pkt();
    p_ok = 0; p_wait = 0;
    for (int i = 0; i < 3 * TIMEOUT_CYC; i++) begin
      if (tx_valid === 1'b1) begin
        p_ok = 1; p_pid = tx_pid; p_addr = tx_addr; p_endp = tx_endp; p_data = tx_data; p_hd = tx_has_data;
        @(negedge clk);
        return;
      end
      p_wait++;
      @(negedge clk);
    end
  endtask

  task automatic send_rx(input logic [3:0] pid, input logic [DATA_W-1:0] d, input logic crc);
    rx_valid = 1'b1; rx_pid = pid; rx_data = d; rx_crc_err = crc;
    @(negedge clk);
    rx_valid = 1'b0; rx_crc_err = 1'b0;
  endtask

  task automatic wait_done();
    w_ok = 0; w_wait = 0;
    for (int i = 0; i < 3 * TIMEOUT_CYC; i++) begin
      if (done === 1'b1) begin
        w_ok = 1; w_code = done_code; w_pay = rx_payload;
        @(negedge clk);
        w_after = done; w_rr = req_ready;
        return;
      end
      w_wait++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_L = 1'b0;
    repeat (3) @(negedge clk);
    rst_L = 1'b1;
    @(negedge clk);
    m_tog = '0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if (tx_valid !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_valid got tx_valid=%b done=%b exp=0", tx_valid, done); end
    total++; if (done_code !== 2'b00 || rx_payload !== '0) begin bad++; $display("FAIL reset_status got code=%b pay=%h exp=0", done_code, rx_payload); end
    total++; if ({tx_pid, tx_addr, tx_endp, tx_has_data} !== '0 || tx_data !== '0) begin bad++; $display("FAIL reset_tx_fields got pid=%h addr=%h endp=%h data=%h exp=0", tx_pid, tx_addr, tx_endp, tx_data); end
  endtask

  task automatic test_out();
    logic [DATA_W-1:0] d;
    for (int k = 0; k < 2; k++) begin
      d = 64'hAABBCCDD + 64'(k);
      do_request(1'b0, 7'h15, 4'd3, d, 1'b0);
      get_pkt();
      total++; if (!p_ok || p_wait != 0 || p_pid !== PID_OUT || p_addr !== 7'h15 || p_endp !== 4'd3 || p_hd !== 1'b0) begin bad++; $display("FAIL out_token got ok=%0d wait=%0d pid=%h addr=%h endp=%h exp pid=%h wait=0", p_ok, p_wait, p_pid, p_addr, p_endp, PID_OUT); end
      get_pkt();
      total++; if (!p_ok || p_wait != 0 || p_pid !== data_pid(m_tog[3]) || p_data !== d || p_hd !== 1'b1) begin bad++; $display("FAIL out_data got ok=%0d wait=%0d pid=%h data=%h exp pid=%h data=%h", p_ok, p_wait, p_pid, p_data, data_pid(m_tog[3]), d); end
      send_rx(PID_ACK, '0, 1'b0);
      m_tog[3] = ~m_tog[3];
      wait_done();
      total++; if (!w_ok || w_code !== 2'b00) begin bad++; $display("FAIL out_done got ok=%0d code=%b exp=00", w_ok, w_code); end
      total++; if (w_after !== 1'b0 || w_rr !== 1'b1) begin bad++; $display("FAIL out_done_pulse got done=%b ready=%b exp 0/1", w_after, w_rr); end
    end
  endtask

  task automatic test_in();
    do_request(1'b1, 7'h22, 4'd2, '0, 1'b0);
    get_pkt();
    total++; if (!p_ok || p_pid !== PID_IN || p_endp !== 4'd2) begin bad++; $display("FAIL in_token got pid=%h endp=%h exp pid=%h", p_pid, p_endp, PID_IN); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL in_busy_ready got=%b exp=0", req_ready); end
    send_rx(data_pid(m_tog[2]), 64'h1234, 1'b0);
    get_pkt();
    total++; if (!p_ok || p_pid !== PID_ACK || p_hd !== 1'b0) begin bad++; $display("FAIL in_ack got ok=%0d pid=%h hd=%b exp pid=%h", p_ok, p_pid, p_hd, PID_ACK); end
    m_tog[2] = ~m_tog[2];
    wait_done();
    total++; if (!w_ok || w_code !== 2'b00 || w_pay !== 64'h1234) begin bad++; $display("FAIL in_done got code=%b pay=%h exp 00/1234", w_code, w_pay); end
    do_request(1'b1, 7'h22, 4'd2, '0, 1'b0);
    get_pkt();
    send_rx(data_pid(~m_tog[2]), 64'h5555, 1'b0);
    get_pkt();
    total++; if (!p_ok || p_pid !== PID_ACK) begin bad++; $display("FAIL in_dup_ack got pid=%h exp=%h", p_pid, PID_ACK); end
    get_pkt();
    total++; if (!p_ok || p_wait != 0 || p_pid !== PID_IN) begin bad++; $display("FAIL in_dup_reissue got pid=%h wait=%0d exp pid=%h", p_pid, p_wait, PID_IN); end
    send_rx(data_pid(m_tog[2]), 64'h9876, 1'b0);
    get_pkt();
    m_tog[2] = ~m_tog[2];
    wait_done();
    total++; if (!w_ok || w_code !== 2'b00 || w_pay !== 64'h9876) begin bad++; $display("FAIL in_dup_done got code=%b pay=%h exp 00/9876", w_code, w_pay); end
  endtask

  // Device model: picks a random reaction per attempt and tracks counts/toggles in plain integers.
  task automatic test_random();
    logic dir;
    logic [6:0] a;
    logic [3:0] e;
    logic [DATA_W-1:0] d, pay;
    logic [1:0] code;
    int r, retries, naks;
    bit fin;
    for (int t = 0; t < 30; t++) begin
      dir = 1'($urandom_range(0, 1)); e = 4'($urandom_range(0, 15)); a = 7'($urandom); d = {$urandom, $urandom};
      do_request(dir, a, e, d, 1'b0);
      retries = 0; naks = 0; fin = 0; code = 2'b00; pay = '0;
      for (int it = 0; it < 80 && !fin; it++) begin
        get_pkt();
        total++; if (!p_ok || p_pid !== (dir ? PID_IN : PID_OUT) || p_addr !== a || p_endp !== e) begin bad++; $display("FAIL rnd_token t=%0d got ok=%0d pid=%h addr=%h endp=%h exp addr=%h endp=%h", t, p_ok, p_pid, p_addr, p_endp, a, e); end
        if (!dir) begin
          get_pkt();
          total++; if (!p_ok || p_pid !== data_pid(m_tog[e]) || p_data !== d || p_hd !== 1'b1) begin bad++; $display("FAIL rnd_data t=%0d got pid=%h data=%h exp pid=%h data=%h", t, p_pid, p_data, data_pid(m_tog[e]), d); end
        end
        r = (it > 24) ? 0 : int'($urandom_range(0, 9));
        if (r <= 3) begin
          if (dir) begin
            pay = {$urandom, $urandom} | 64'h1;
            send_rx(data_pid(m_tog[e]), pay, 1'b0);
            get_pkt();
            total++; if (!p_ok || p_pid !== PID_ACK || p_hd !== 1'b0) begin bad++; $display("FAIL rnd_ack t=%0d got pid=%h exp=%h", t, p_pid, PID_ACK); end
          end else begin
            send_rx(PID_ACK, '0, 1'b0);
          end
          m_tog[e] = ~m_tog[e]; fin = 1; code = 2'b00;
        end else if (r == 4) begin
          send_rx(PID_NAK, '0, 1'b0);
          naks++;
          if (naks == NAK_LIMIT) begin fin = 1; code = 2'b10; end
        end else if (r == 5) begin
          send_rx(PID_STALL, '0, 1'b0);
          fin = 1; code = 2'b11;
        end else if (r == 7 && dir) begin
          send_rx(data_pid(~m_tog[e]), {$urandom, $urandom}, 1'b0);
          get_pkt();
          total++; if (!p_ok || p_pid !== PID_ACK) begin bad++; $display("FAIL rnd_dup_ack t=%0d got pid=%h exp=%h", t, p_pid, PID_ACK); end
        end else begin
          if (r == 6) send_rx(dir ? data_pid(m_tog[e]) : PID_ACK, d, 1'b1);
          else if (r == 7) send_rx(PID_DATA0, '0, 1'b0);
          else if (r == 9 && !dir) send_rx(PID_IN, '0, 1'b0);
          retries++;
          if (retries == MAX_RETRY) begin fin = 1; code = 2'b01; end
        end
      end
      wait_done();
      total++; if (!w_ok || w_code !== code) begin bad++; $display("FAIL rnd_done t=%0d got ok=%0d code=%b exp=%b", t, w_ok, w_code, code); end
      if (code == 2'b00 && dir) begin
        total++; if (w_pay !== pay) begin bad++; $display("FAIL rnd_payload t=%0d got=%h exp=%h", t, w_pay, pay); end
      end
    end
  endtask

  task automatic test_timeout();
    logic [DATA_W-1:0] d;
    d = {$urandom, $urandom};
    do_request(1'b0, 7'h05, 4'd5, d, 1'b0);
    for (int i = 0; i < MAX_RETRY; i++) begin
      get_pkt();
      total++; if (!p_ok || p_pid !== PID_OUT || (i > 0 && p_wait != TIMEOUT_CYC)) begin bad++; $display("FAIL tmo_token i=%0d got ok=%0d pid=%h wait=%0d exp wait=%0d", i, p_ok, p_pid, p_wait, TIMEOUT_CYC); end
      get_pkt();
      total++; if (!p_ok || p_pid !== data_pid(m_tog[5]) || p_data !== d) begin bad++; $display("FAIL tmo_data i=%0d got pid=%h data=%h exp pid=%h", i, p_pid, p_data, data_pid(m_tog[5])); end
    end
    wait_done();
    total++; if (!w_ok || w_code !== 2'b01 || w_wait != TIMEOUT_CYC) begin bad++; $display("FAIL tmo_done got ok=%0d code=%b wait=%0d exp 01/%0d", w_ok, w_code, w_wait, TIMEOUT_CYC); end
  endtask

  task automatic test_crc();
    do_request(1'b1, 7'h31, 4'd2, '0, 1'b0);
    for (int i = 0; i < MAX_RETRY; i++) begin
      get_pkt();
      total++; if (!p_ok || p_pid !== PID_IN || (i > 0 && p_wait != 0)) begin bad++; $display("FAIL crc_token i=%0d got pid=%h wait=%0d exp pid=%h wait=0", i, p_pid, p_wait, PID_IN); end
      send_rx(data_pid(m_tog[2]), 64'hDEAD, 1'b1);
    end
    wait_done();
    total++; if (!w_ok || w_code !== 2'b01 || w_wait != 0) begin bad++; $display("FAIL crc_done got ok=%0d code=%b wait=%0d exp 01/0", w_ok, w_code, w_wait); end
  endtask

  task automatic test_nak();
    do_request(1'b1, 7'h06, 4'd6, '0, 1'b0);
    for (int i = 0; i < NAK_LIMIT; i++) begin
      get_pkt();
      total++; if (!p_ok || p_pid !== PID_IN) begin bad++; $display("FAIL nak_token i=%0d got ok=%0d pid=%h exp=%h", i, p_ok, p_pid, PID_IN); end
      send_rx(PID_NAK, '0, 1'b0);
    end
    wait_done();
    total++; if (!w_ok || w_code !== 2'b10 || w_wait != 0) begin bad++; $display("FAIL nak_done got ok=%0d code=%b wait=%0d exp 10/0", w_ok, w_code, w_wait); end
  endtask

  task automatic test_tog_clr();
    logic [DATA_W-1:0] d;
    d = {$urandom, $urandom};
    for (int k = 0; k < 2; k++) begin
      if (k == 0 || !m_tog[9]) begin
        do_request(1'b0, 7'h01, 4'd9, d, 1'b0);
        get_pkt();
        get_pkt();
        total++; if (!p_ok || p_pid !== data_pid(m_tog[9])) begin bad++; $display("FAIL clr_pre_data got pid=%h exp=%h", p_pid, data_pid(m_tog[9])); end
        send_rx(PID_ACK, '0, 1'b0);
        m_tog[9] = ~m_tog[9];
        wait_done();
      end
    end
    do_request(1'b0, 7'h01, 4'd9, d, 1'b1);
    m_tog = '0;
    get_pkt();
    get_pkt();
    total++; if (!p_ok || p_pid !== PID_DATA0 || p_pid !== data_pid(m_tog[9])) begin bad++; $display("FAIL clr_data got pid=%h exp=%h", p_pid, PID_DATA0); end
    send_rx(PID_ACK, '0, 1'b0);
    m_tog[9] = ~m_tog[9];
    wait_done();
    total++; if (!w_ok || w_code !== 2'b00) begin bad++; $display("FAIL clr_done got ok=%0d code=%b exp=00", w_ok, w_code); end
  endtask

  task automatic test_stall();
    do_request(1'b1, 7'h07, 4'd7, '0, 1'b0);
    get_pkt();
    send_rx(PID_STALL, '0, 1'b0);
    wait_done();
    total++; if (!w_ok || w_code !== 2'b11 || w_wait != 0) begin bad++; $display("FAIL stall_done got ok=%0d code=%b wait=%0d exp 11/0", w_ok, w_code, w_wait); end
  endtask

  task automatic test_tx_stall_reset();
    logic [DATA_W-1:0] d;
    logic [3:0] hp;
    d = {$urandom, $urandom};
    do_request(1'b0, 7'h44, 4'd4, d, 1'b0);
    get_pkt();
    tx_ready = 1'b0;
    hp = tx_pid;
    total++; if (tx_valid !== 1'b1 || hp !== data_pid(m_tog[4])) begin bad++; $display("FAIL hold_first got valid=%b pid=%h exp pid=%h", tx_valid, hp, data_pid(m_tog[4])); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (tx_valid !== 1'b1 || tx_pid !== hp || tx_data !== d || tx_has_data !== 1'b1) begin bad++; $display("FAIL hold_stable k=%0d got valid=%b pid=%h data=%h exp pid=%h data=%h", k, tx_valid, tx_pid, tx_data, hp, d); end
    end
    tx_ready = 1'b1;
    get_pkt();
    get_pkt();
    total++; if (!p_ok || p_pid !== PID_OUT || p_wait != TIMEOUT_CYC) begin bad++; $display("FAIL hold_timeout got pid=%h wait=%0d exp wait=%0d", p_pid, p_wait, TIMEOUT_CYC); end
    get_pkt();
    repeat (3) @(negedge clk);
    rst_L = 1'b0;
    #1;
    total++; if (tx_valid !== 1'b0 || done !== 1'b0 || done_code !== 2'b00 || rx_payload !== '0) begin bad++; $display("FAIL async_reset_status got valid=%b done=%b code=%b pay=%h exp 0", tx_valid, done, done_code, rx_payload); end
    total++; if ({tx_pid, tx_addr, tx_endp, tx_has_data} !== '0 || tx_data !== '0) begin bad++; $display("FAIL async_reset_tx got pid=%h addr=%h data=%h exp 0", tx_pid, tx_addr, tx_data); end
    @(negedge clk);
    rst_L = 1'b1;
    m_tog = '0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL async_reset_ready got=%b exp=1", req_ready); end
    do_request(1'b0, 7'h44, 4'd9, d, 1'b0);
    get_pkt();
    get_pkt();
    total++; if (!p_ok || p_pid !== data_pid(m_tog[9])) begin bad++; $display("FAIL reset_toggle_clear got pid=%h exp=%h", p_pid, data_pid(m_tog[9])); end
    send_rx(PID_ACK, '0, 1'b0);
    wait_done();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_L = 1'b0; req_valid = 1'b0; req_dir = 1'b0; req_addr = '0; req_endp = '0; req_data = '0;
    tog_clr = 1'b0; tx_ready = 1'b1; rx_valid = 1'b0; rx_pid = '0; rx_data = '0; rx_crc_err = 1'b0;
    m_tog = '0;
    @(negedge clk);
    test_reset();
    test_out();
    test_in();
    test_random();
    test_timeout();
    test_crc();
    test_nak();
    test_tog_clr();
    test_stall();
    test_tx_stall_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
